// File: rtl/xadac_pkg.sv
// Shared types and sizing for the xadac accelerator blocks.
package xadac_pkg;

    localparam int SbLen        = 4;
    localparam int IdWidth      = $clog2(SbLen);
    localparam int AddrWidth    = 32;
    localparam int RegDataWidth = 32;
    localparam int InstrWidth   = 32;
    localparam int VecDataWidth = 64;
    localparam int VecElemWidth = 8;
    localparam int VecLenWidth  = 4;
    localparam int NumRs        = 2;
    localparam int NumVs        = 3;

    typedef logic [IdWidth-1:0]      IdT;
    typedef logic [AddrWidth-1:0]    AddrT;
    typedef logic [RegDataWidth-1:0] RegDataT;
    typedef logic [InstrWidth-1:0]   InstrT;
    typedef logic [VecDataWidth-1:0] VecDataT;
    typedef logic [VecLenWidth-1:0]  VecLenT;

    typedef struct packed {
        IdT    id;
        InstrT instr;
    } dec_req_t;

    typedef struct packed {
        IdT               id;
        logic [NumRs-1:0] rs_read;
        logic [NumVs-1:0] vs_read;
        logic             rd_clobber;
        logic             vd_clobber;
        logic             accept;
    } dec_rsp_t;

    typedef struct packed {
        IdT                                 id;
        InstrT                              instr;
        logic [NumRs-1:0][RegDataWidth-1:0] rs_data;
    } exe_req_t;

    typedef struct packed {
        IdT      id;
        logic    rd_write;
        RegDataT rd_data;
        logic    vd_write;
        VecDataT vd_data;
    } exe_rsp_t;

endpackage

// File: rtl/xadac_if.sv
// xadac decode/execute handshake bundle shared by the functional units.
interface xadac_if;
    import xadac_pkg::*;

    dec_req_t dec_req;
    logic     dec_req_valid;
    logic     dec_req_ready;
    dec_rsp_t dec_rsp;
    logic     dec_rsp_valid;
    logic     dec_rsp_ready;
    exe_req_t exe_req;
    logic     exe_req_valid;
    logic     exe_req_ready;
    exe_rsp_t exe_rsp;
    logic     exe_rsp_valid;
    logic     exe_rsp_ready;

    modport slv (
        input  dec_req, dec_req_valid, dec_rsp_ready, exe_req, exe_req_valid, exe_rsp_ready,
        output dec_req_ready, dec_rsp, dec_rsp_valid, exe_req_ready, exe_rsp, exe_rsp_valid
    );

    modport mst (
        output dec_req, dec_req_valid, dec_rsp_ready, exe_req, exe_req_valid, exe_rsp_ready,
        input  dec_req_ready, dec_rsp, dec_rsp_valid, exe_req_ready, exe_rsp, exe_rsp_valid
    );

endinterface

// File: rtl/xadac_vload.sv
// xadac vector load unit: one AXI read per instruction, zero-masked beyond vlen,
// returned as a vd write. A per-id scoreboard lets up to SbLen loads overlap.
module xadac_vload
    import xadac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    xadac_if.slv                    slv,
    output logic [IdWidth-1:0]      axi_ar_id,
    output logic [AddrWidth-1:0]    axi_ar_addr,
    output logic                    axi_ar_valid,
    input  logic                    axi_ar_ready,
    input  logic [IdWidth-1:0]      axi_r_id,
    input  logic [VecDataWidth-1:0] axi_r_data,
    input  logic                    axi_r_valid,
    output logic                    axi_r_ready
);

    localparam int NumElem = VecDataWidth / VecElemWidth;

    typedef struct packed {
        AddrT    addr;
        VecLenT  vlen;
        VecDataT data;
        logic    exe_req_done;
        logic    axi_ar_done;
        logic    axi_r_done;
        logic    exe_rsp_done;
    } sb_entry_t;

    // Zero every element whose index is at or beyond vlen.
    function automatic VecDataT mask_vec(input VecDataT data, input VecLenT vlen);
        VecDataT res;
        res = data;
        for (int i = 0; i < NumElem; i++) begin
            if (32'(i) >= 32'(vlen)) begin
                res[i*VecElemWidth +: VecElemWidth] = {VecElemWidth{1'b0}};
            end else begin
                res[i*VecElemWidth +: VecElemWidth] = data[i*VecElemWidth +: VecElemWidth];
            end
        end
        return res;
    endfunction

    sb_entry_t sb_q [SbLen];
    sb_entry_t sb_d [SbLen];

    logic     ar_valid_q;
    IdT       ar_id_q;
    AddrT     ar_addr_q;
    logic     ar_valid_d;
    IdT       ar_id_d;
    AddrT     ar_addr_d;
    logic     rsp_valid_q;
    exe_rsp_t rsp_q;
    logic     rsp_valid_d;
    exe_rsp_t rsp_d;

    logic     exe_req_ready_s;
    logic     axi_r_ready_s;
    logic     ar_found_s;
    IdT       ar_sel_s;
    logic     rsp_found_s;
    IdT       rsp_sel_s;
    dec_rsp_t dec_rsp_s;
    logic     unused_s;

    // Decode always accepts and claims rs1 plus the vd destination.
    always_comb begin
        dec_rsp_s            = {$bits(dec_rsp_t){1'b0}};
        dec_rsp_s.id         = slv.dec_req.id;
        dec_rsp_s.rs_read    = {{(NumRs-1){1'b0}}, 1'b1};
        dec_rsp_s.vs_read    = {NumVs{1'b0}};
        dec_rsp_s.rd_clobber = 1'b0;
        dec_rsp_s.vd_clobber = 1'b1;
        dec_rsp_s.accept     = 1'b1;
    end

    assign slv.dec_rsp       = dec_rsp_s;
    assign slv.dec_rsp_valid = slv.dec_req_valid;
    assign slv.dec_req_ready = slv.dec_req_valid & slv.dec_rsp_ready;

    // Handshake readies are judged on the registered scoreboard only.
    assign exe_req_ready_s = slv.exe_req_valid & ~sb_q[slv.exe_req.id].exe_req_done;
    assign axi_r_ready_s   = axi_r_valid & sb_q[axi_r_id].axi_ar_done & ~sb_q[axi_r_id].axi_r_done;

    assign slv.exe_req_ready = exe_req_ready_s;
    assign axi_r_ready       = axi_r_ready_s;
    assign slv.exe_rsp       = rsp_q;
    assign slv.exe_rsp_valid = rsp_valid_q;
    assign axi_ar_id         = ar_id_q;
    assign axi_ar_addr       = ar_addr_q;
    assign axi_ar_valid      = ar_valid_q;

    // Instruction bits outside vlen and the second source operand are not needed here.
    assign unused_s = ^{slv.dec_req.instr, slv.exe_req.instr, slv.exe_req.rs_data[1]};

    // Scoreboard next state: exe req, AR, R, rsp, then clean, applied in that order.
    always_comb begin
        sb_d        = sb_q;
        ar_valid_d  = ar_valid_q;
        ar_id_d     = ar_id_q;
        ar_addr_d   = ar_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        ar_found_s  = 1'b0;
        ar_sel_s    = {IdWidth{1'b0}};
        rsp_found_s = 1'b0;
        rsp_sel_s   = {IdWidth{1'b0}};

        if (exe_req_ready_s) begin
            sb_d[slv.exe_req.id].addr         = slv.exe_req.rs_data[0];
            sb_d[slv.exe_req.id].vlen         = slv.exe_req.instr[25 +: VecLenWidth];
            sb_d[slv.exe_req.id].exe_req_done = 1'b1;
        end else begin
        end

        if (!ar_valid_q || axi_ar_ready) begin
            ar_valid_d = 1'b0;
            for (int i = 0; i < SbLen; i++) begin
                if (!ar_found_s && sb_d[i].exe_req_done && !sb_d[i].axi_ar_done) begin
                    ar_found_s = 1'b1;
                    ar_sel_s   = IdT'(i);
                end else begin
                end
            end
            if (ar_found_s) begin
                ar_valid_d                  = 1'b1;
                ar_id_d                     = ar_sel_s;
                ar_addr_d                   = sb_d[ar_sel_s].addr;
                sb_d[ar_sel_s].axi_ar_done  = 1'b1;
            end else begin
            end
        end else begin
        end

        if (axi_r_ready_s) begin
            sb_d[axi_r_id].data       = mask_vec(axi_r_data, sb_q[axi_r_id].vlen);
            sb_d[axi_r_id].axi_r_done = 1'b1;
        end else begin
        end

        if (!rsp_valid_q || slv.exe_rsp_ready) begin
            rsp_valid_d = 1'b0;
            for (int i = 0; i < SbLen; i++) begin
                if (!rsp_found_s && sb_d[i].axi_r_done && !sb_d[i].exe_rsp_done) begin
                    rsp_found_s = 1'b1;
                    rsp_sel_s   = IdT'(i);
                end else begin
                end
            end
            if (rsp_found_s) begin
                rsp_valid_d                  = 1'b1;
                rsp_d                        = {$bits(exe_rsp_t){1'b0}};
                rsp_d.id                     = rsp_sel_s;
                rsp_d.vd_write               = 1'b1;
                rsp_d.vd_data                = sb_d[rsp_sel_s].data;
                sb_d[rsp_sel_s].exe_rsp_done = 1'b1;
            end else begin
            end
        end else begin
        end

        // An id still sitting in the response register stays busy until it is delivered.
        for (int i = 0; i < SbLen; i++) begin
            if (sb_d[i].exe_req_done && sb_d[i].axi_ar_done && sb_d[i].axi_r_done &&
                sb_d[i].exe_rsp_done && !(rsp_valid_d && (rsp_d.id == IdT'(i)))) begin
                sb_d[i] = {$bits(sb_entry_t){1'b0}};
            end else begin
            end
        end
    end

    // State registers; reset drops every in-flight load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SbLen; i++) begin
                sb_q[i] <= {$bits(sb_entry_t){1'b0}};
            end
            ar_valid_q  <= 1'b0;
            ar_id_q     <= {IdWidth{1'b0}};
            ar_addr_q   <= {AddrWidth{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_q       <= {$bits(exe_rsp_t){1'b0}};
        end else begin
            sb_q        <= sb_d;
            ar_valid_q  <= ar_valid_d;
            ar_id_q     <= ar_id_d;
            ar_addr_q   <= ar_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

endmodule

// File: tb/tb_xadac_vload.sv
// Directed bench for xadac_vload with hand-computed expectations.
module tb_xadac_vload;
    import xadac_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    xadac_if vif();

    logic [IdWidth-1:0]      axi_ar_id;
    logic [AddrWidth-1:0]    axi_ar_addr;
    logic                    axi_ar_valid;
    logic                    axi_ar_ready;
    logic [IdWidth-1:0]      axi_r_id;
    logic [VecDataWidth-1:0] axi_r_data;
    logic                    axi_r_valid;
    logic                    axi_r_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    xadac_vload dut (
        .clk          (clk),
        .rstn         (rstn),
        .slv          (vif),
        .axi_ar_id    (axi_ar_id),
        .axi_ar_addr  (axi_ar_addr),
        .axi_ar_valid (axi_ar_valid),
        .axi_ar_ready (axi_ar_ready),
        .axi_r_id     (axi_r_id),
        .axi_r_data   (axi_r_data),
        .axi_r_valid  (axi_r_valid),
        .axi_r_ready  (axi_r_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exe_rsp_t mk_rsp(input IdT id, input VecDataT d);
        exe_rsp_t r;
        r          = {$bits(exe_rsp_t){1'b0}};
        r.id       = id;
        r.vd_write = 1'b1;
        r.vd_data  = d;
        return r;
    endfunction

    task automatic set_req(input IdT id, input AddrT a, input VecLenT v);
        InstrT ins;
        ins                    = 32'h0000_0000;
        ins[25 +: VecLenWidth] = v;
        vif.exe_req.id         = id;
        vif.exe_req.instr      = ins;
        vif.exe_req.rs_data[0] = a;
        vif.exe_req.rs_data[1] = 32'hDEAD_BEEF;
        vif.exe_req_valid      = 1'b1;
    endtask

    task automatic test_reset();
        dec_rsp_t exp_dec;
        rstn = 1'b0;
        step(); step();
        n_cmp++; if (axi_ar_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ar_valid got=%b want=0", axi_ar_valid); end
        n_cmp++; if (axi_ar_id !== 2'd0) begin n_fail++; $display("FAIL rst_ar_id got=%h want=0", axi_ar_id); end
        n_cmp++; if (axi_ar_addr !== 32'h0) begin n_fail++; $display("FAIL rst_ar_addr got=%h want=0", axi_ar_addr); end
        n_cmp++; if (vif.exe_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b want=0", vif.exe_rsp_valid); end
        n_cmp++; if (vif.exe_rsp !== {$bits(exe_rsp_t){1'b0}}) begin n_fail++; $display("FAIL rst_rsp got=%h want=0", vif.exe_rsp); end
        rstn = 1'b1;
        step();
        vif.dec_req.id     = 2'd3;
        vif.dec_req.instr  = 32'h1234_5678;
        vif.dec_req_valid  = 1'b1;
        vif.dec_rsp_ready  = 1'b1;
        #1;
        exp_dec            = {$bits(dec_rsp_t){1'b0}};
        exp_dec.id         = 2'd3;
        exp_dec.rs_read    = 2'b01;
        exp_dec.vd_clobber = 1'b1;
        exp_dec.accept     = 1'b1;
        n_cmp++; if (vif.dec_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL dec_rsp_valid got=%b want=1", vif.dec_rsp_valid); end
        n_cmp++; if (vif.dec_req_ready !== 1'b1) begin n_fail++; $display("FAIL dec_req_ready got=%b want=1", vif.dec_req_ready); end
        n_cmp++; if (vif.dec_rsp !== exp_dec) begin n_fail++; $display("FAIL dec_rsp got=%h want=%h", vif.dec_rsp, exp_dec); end
        vif.dec_rsp_ready = 1'b0;
        #1;
        n_cmp++; if (vif.dec_req_ready !== 1'b0) begin n_fail++; $display("FAIL dec_req_ready_stall got=%b want=0", vif.dec_req_ready); end
        vif.dec_req_valid = 1'b0;
        step();
    endtask

    task automatic test_single();
        set_req(2'd2, 32'h0000_1000, 4'd4);
        #1;
        n_cmp++; if (vif.exe_req_ready !== 1'b1) begin n_fail++; $display("FAIL single_req_ready got=%b want=1", vif.exe_req_ready); end
        step();
        vif.exe_req_valid = 1'b0;
        n_cmp++; if (axi_ar_valid !== 1'b1) begin n_fail++; $display("FAIL single_ar_valid got=%b want=1", axi_ar_valid); end
        n_cmp++; if (axi_ar_id !== 2'd2) begin n_fail++; $display("FAIL single_ar_id got=%h want=2", axi_ar_id); end
        n_cmp++; if (axi_ar_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL single_ar_addr got=%h want=00001000", axi_ar_addr); end
        step();
        n_cmp++; if (axi_ar_valid !== 1'b0) begin n_fail++; $display("FAIL single_ar_drop got=%b want=0", axi_ar_valid); end
        axi_r_valid = 1'b1; axi_r_id = 2'd2; axi_r_data = 64'h8877_6655_4433_2211;
        #1;
        n_cmp++; if (axi_r_ready !== 1'b1) begin n_fail++; $display("FAIL single_r_ready got=%b want=1", axi_r_ready); end
        step();
        axi_r_valid = 1'b0;
        n_cmp++; if (vif.exe_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%b want=1", vif.exe_rsp_valid); end
        n_cmp++; if (vif.exe_rsp !== mk_rsp(2'd2, 64'h0000_0000_4433_2211)) begin n_fail++; $display("FAIL single_rsp got=%h want=%h", vif.exe_rsp, mk_rsp(2'd2, 64'h0000_0000_4433_2211)); end
        step();
        n_cmp++; if (vif.exe_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop got=%b want=0", vif.exe_rsp_valid); end
    endtask

    task automatic test_ar_backpressure();
        axi_ar_ready = 1'b0;
        set_req(2'd1, 32'h0000_2000, 4'd8);
        #1;
        n_cmp++; if (vif.exe_req_ready !== 1'b1) begin n_fail++; $display("FAIL arbp_req_ready got=%b want=1", vif.exe_req_ready); end
        step();
        vif.exe_req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if ({axi_ar_valid, axi_ar_id, axi_ar_addr} !== {1'b1, 2'd1, 32'h0000_2000}) begin n_fail++; $display("FAIL arbp_hold cyc=%0d got=%b/%h/%h want=1/1/00002000", k, axi_ar_valid, axi_ar_id, axi_ar_addr); end
            n_cmp++; if (vif.exe_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL arbp_no_rsp cyc=%0d got=%b want=0", k, vif.exe_rsp_valid); end
            if (k < 5) step();
        end
        axi_ar_ready = 1'b1;
        step();
        n_cmp++; if (axi_ar_valid !== 1'b0) begin n_fail++; $display("FAIL arbp_ar_drop got=%b want=0", axi_ar_valid); end
        axi_r_valid = 1'b1; axi_r_id = 2'd1; axi_r_data = 64'h0123_4567_89AB_CDEF;
        #1;
        n_cmp++; if (axi_r_ready !== 1'b1) begin n_fail++; $display("FAIL arbp_r_ready got=%b want=1", axi_r_ready); end
        step();
        axi_r_valid = 1'b0;
        n_cmp++; if (vif.exe_rsp_valid !== 1'b1 || vif.exe_rsp !== mk_rsp(2'd1, 64'h0123_4567_89AB_CDEF)) begin n_fail++; $display("FAIL arbp_rsp got=%b/%h want=1/%h", vif.exe_rsp_valid, vif.exe_rsp, mk_rsp(2'd1, 64'h0123_4567_89AB_CDEF)); end
        step();
    endtask

    task automatic test_out_of_order();
        set_req(2'd0, 32'h0000_3000, 4'd0);
        #1;
        n_cmp++; if (vif.exe_req_ready !== 1'b1) begin n_fail++; $display("FAIL ooo_req0_ready got=%b want=1", vif.exe_req_ready); end
        step();
        set_req(2'd1, 32'h0000_3100, 4'd15);
        #1;
        n_cmp++; if (vif.exe_req_ready !== 1'b1) begin n_fail++; $display("FAIL ooo_req1_ready got=%b want=1", vif.exe_req_ready); end
        n_cmp++; if ({axi_ar_valid, axi_ar_id, axi_ar_addr} !== {1'b1, 2'd0, 32'h0000_3000}) begin n_fail++; $display("FAIL ooo_ar0 got=%b/%h/%h want=1/0/00003000", axi_ar_valid, axi_ar_id, axi_ar_addr); end
        step();
        vif.exe_req_valid = 1'b0;
        n_cmp++; if ({axi_ar_valid, axi_ar_id, axi_ar_addr} !== {1'b1, 2'd1, 32'h0000_3100}) begin n_fail++; $display("FAIL ooo_ar1 got=%b/%h/%h want=1/1/00003100", axi_ar_valid, axi_ar_id, axi_ar_addr); end
        step();
        axi_r_valid = 1'b1; axi_r_id = 2'd1; axi_r_data = 64'hFFEE_DDCC_BBAA_9988;
        #1;
        n_cmp++; if (axi_r_ready !== 1'b1) begin n_fail++; $display("FAIL ooo_r1_ready got=%b want=1", axi_r_ready); end
        step();
        axi_r_id = 2'd0; axi_r_data = 64'h1111_1111_1111_1111;
        #1;
        n_cmp++; if (axi_r_ready !== 1'b1) begin n_fail++; $display("FAIL ooo_r0_ready got=%b want=1", axi_r_ready); end
        n_cmp++; if (vif.exe_rsp_valid !== 1'b1 || vif.exe_rsp !== mk_rsp(2'd1, 64'hFFEE_DDCC_BBAA_9988)) begin n_fail++; $display("FAIL ooo_rsp1 got=%b/%h want=1/%h", vif.exe_rsp_valid, vif.exe_rsp, mk_rsp(2'd1, 64'hFFEE_DDCC_BBAA_9988)); end
        step();
        axi_r_valid = 1'b0;
        n_cmp++; if (vif.exe_rsp_valid !== 1'b1 || vif.exe_rsp !== mk_rsp(2'd0, 64'h0)) begin n_fail++; $display("FAIL ooo_rsp0 got=%b/%h want=1/%h", vif.exe_rsp_valid, vif.exe_rsp, mk_rsp(2'd0, 64'h0)); end
        step();
        n_cmp++; if (vif.exe_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_rsp_drop got=%b want=0", vif.exe_rsp_valid); end
    endtask

    task automatic test_unknown_r();
        axi_r_valid = 1'b1; axi_r_id = 2'd3; axi_r_data = 64'h5555_5555_5555_5555;
        set_req(2'd0, 32'h0000_4000, 4'd2);
        #1;
        n_cmp++; if (axi_r_ready !== 1'b0) begin n_fail++; $display("FAIL unk_r_ready0 got=%b want=0", axi_r_ready); end
        n_cmp++; if (vif.exe_req_ready !== 1'b1) begin n_fail++; $display("FAIL unk_req_ready got=%b want=1", vif.exe_req_ready); end
        step();
        vif.exe_req_valid = 1'b0;
        n_cmp++; if ({axi_ar_valid, axi_ar_id, axi_ar_addr} !== {1'b1, 2'd0, 32'h0000_4000}) begin n_fail++; $display("FAIL unk_ar got=%b/%h/%h want=1/0/00004000", axi_ar_valid, axi_ar_id, axi_ar_addr); end
        n_cmp++; if (axi_r_ready !== 1'b0) begin n_fail++; $display("FAIL unk_r_ready1 got=%b want=0", axi_r_ready); end
        step();
        n_cmp++; if (axi_r_ready !== 1'b0) begin n_fail++; $display("FAIL unk_r_ready2 got=%b want=0", axi_r_ready); end
        n_cmp++; if (vif.exe_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL unk_no_rsp got=%b want=0", vif.exe_rsp_valid); end
        axi_r_id = 2'd0; axi_r_data = 64'hAABB_CCDD_EEFF_0011;
        #1;
        n_cmp++; if (axi_r_ready !== 1'b1) begin n_fail++; $display("FAIL unk_r0_ready got=%b want=1", axi_r_ready); end
        step();
        axi_r_valid = 1'b0;
        n_cmp++; if (vif.exe_rsp_valid !== 1'b1 || vif.exe_rsp !== mk_rsp(2'd0, 64'h0000_0000_0000_0011)) begin n_fail++; $display("FAIL unk_rsp got=%b/%h want=1/%h", vif.exe_rsp_valid, vif.exe_rsp, mk_rsp(2'd0, 64'h0000_0000_0000_0011)); end
        step();
    endtask

    task automatic test_rsp_backpressure_reuse();
        vif.exe_rsp_ready = 1'b0;
        set_req(2'd3, 32'h0000_5000, 4'd6);
        #1;
        n_cmp++; if (vif.exe_req_ready !== 1'b1) begin n_fail++; $display("FAIL rbp_req_ready got=%b want=1", vif.exe_req_ready); end
        step();
        vif.exe_req_valid = 1'b0;
        step();
        axi_r_valid = 1'b1; axi_r_id = 2'd3; axi_r_data = 64'h0807_0605_0403_0201;
        #1;
        n_cmp++; if (axi_r_ready !== 1'b1) begin n_fail++; $display("FAIL rbp_r_ready got=%b want=1", axi_r_ready); end
        step();
        axi_r_valid = 1'b0;
        set_req(2'd3, 32'h0000_6000, 4'd3);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (vif.exe_rsp_valid !== 1'b1 || vif.exe_rsp !== mk_rsp(2'd3, 64'h0000_0605_0403_0201)) begin n_fail++; $display("FAIL rbp_hold cyc=%0d got=%b/%h want=1/%h", k, vif.exe_rsp_valid, vif.exe_rsp, mk_rsp(2'd3, 64'h0000_0605_0403_0201)); end
            n_cmp++; if (vif.exe_req_ready !== 1'b0) begin n_fail++; $display("FAIL rbp_reuse_early cyc=%0d got=%b want=0", k, vif.exe_req_ready); end
            if (k < 3) step();
        end
        vif.exe_rsp_ready = 1'b1;
        #1;
        n_cmp++; if (vif.exe_req_ready !== 1'b0) begin n_fail++; $display("FAIL rbp_reuse_fire_cyc got=%b want=0", vif.exe_req_ready); end
        step();
        n_cmp++; if (vif.exe_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rbp_rsp_drop got=%b want=0", vif.exe_rsp_valid); end
        n_cmp++; if (vif.exe_req_ready !== 1'b1) begin n_fail++; $display("FAIL rbp_reuse_ready got=%b want=1", vif.exe_req_ready); end
        step();
        vif.exe_req_valid = 1'b0;
        n_cmp++; if ({axi_ar_valid, axi_ar_id, axi_ar_addr} !== {1'b1, 2'd3, 32'h0000_6000}) begin n_fail++; $display("FAIL rbp_reuse_ar got=%b/%h/%h want=1/3/00006000", axi_ar_valid, axi_ar_id, axi_ar_addr); end
    endtask

    task automatic test_reset_midflight();
        step();
        axi_ar_ready = 1'b0;
        set_req(2'd0, 32'h0000_7000, 4'd1);
        #1;
        n_cmp++; if (vif.exe_req_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_req_ready got=%b want=1", vif.exe_req_ready); end
        step();
        vif.exe_req_valid = 1'b0;
        n_cmp++; if ({axi_ar_valid, axi_ar_id} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL rmf_ar_pending got=%b/%h want=1/0", axi_ar_valid, axi_ar_id); end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++; if (axi_ar_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_ar_valid got=%b want=0", axi_ar_valid); end
        n_cmp++; if (vif.exe_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_rsp_valid got=%b want=0", vif.exe_rsp_valid); end
        step(); step();
        rstn = 1'b1;
        step();
        for (int i = 0; i < SbLen; i++) begin
            set_req(IdT'(i), 32'h0000_8000, 4'd1);
            #1;
            n_cmp++; if (vif.exe_req_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_id_free id=%0d got=%b want=1", i, vif.exe_req_ready); end
            vif.exe_req_valid = 1'b0;
            step();
        end
        n_cmp++; if (axi_ar_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_ar_idle got=%b want=0", axi_ar_valid); end
        axi_ar_ready = 1'b1;
    endtask

    initial begin
        rstn              = 1'b0;
        vif.dec_req       = {$bits(dec_req_t){1'b0}};
        vif.dec_req_valid = 1'b0;
        vif.dec_rsp_ready = 1'b0;
        vif.exe_req       = {$bits(exe_req_t){1'b0}};
        vif.exe_req_valid = 1'b0;
        vif.exe_rsp_ready = 1'b1;
        axi_ar_ready      = 1'b1;
        axi_r_id          = 2'd0;
        axi_r_data        = 64'h0;
        axi_r_valid       = 1'b0;

        test_reset();
        test_single();
        test_ar_backpressure();
        test_out_of_order();
        test_unknown_r();
        test_rsp_backpressure_reuse();
        test_reset_midflight();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
